booth_r4_seq_mult: RTL
======================

Name: booth_r4_seq_mult

Overview:
- Sequential radix-4 Booth signed multiplier controller for the approximate-processor datapath.
- Sits upstream of the Booth partial-sum row. Each cycle it supplies the row with the multiplicand, the current Booth triplet and the previous partial sum. It then consumes the 18-bit row result, shifts it and accumulates.
- One 16x16 product is produced every 8 compute cycles, with valid/ready handshakes on both sides.
- An optional approximation mode drops the least-significant Booth digits to save switching power.

Parameters:
- APPROX_ROWS, 0, number of least-significant Booth digits (0..7) forced to zero; 0 gives an exact product.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a  input  16  multiplicand, two's complement.
- b  input  16  multiplier, two's complement.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- p  output  32  signed product, two's complement.
- busy  output  1  high while in CALC.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset (rst sampled high at clk edge):
  - state=IDLE, cnt=0, accumulators=0, p=0, out_valid=0, busy=0.
  - in_ready=0 while rst is high; in_ready=1 from the first cycle after release.
  - Reset has priority over all other events. Reset mid-CALC or mid-HOLD aborts silently: no out_valid and no partial result on p.
- FSM states: IDLE, CALC, HOLD.
  - IDLE: in_ready=1. On in_valid&&in_ready: latch a, b; set acc_hi(18b)=0, lo(16b)=b, prev=0, cnt=0; go to CALC.
  - CALC: in_ready=0, busy=1. Each edge processes Booth digit i=cnt.
    - Digit rule: triplet {lo[1],lo[0],prev}, d = -2*t2 + t1 + t0, d in {-2..+2}.
    - If i<APPROX_ROWS then d=0.
    - sum = acc_hi + d*a, computed at 18 bits with sign extension.
    - {acc_hi,lo} = arithmetic right shift by 2 of {sum,lo}; prev = old lo[1]; cnt++.
    - On cnt==7: load p = {acc_hi[15:0], lo} from the shifted value; go to HOLD.
  - HOLD: out_valid=1, p held stable, in_ready=0. On out_ready: out_valid=0 next cycle; go to IDLE.
- Latency: out_valid rises exactly 8 clock edges after the accepting edge. Minimum initiation interval is 10 cycles (accept, 8 CALC, HOLD with out_ready high).
- Arithmetic:
  - With APPROX_ROWS=0, p = a*b exactly for all 2^32 operand pairs, including a=b=-32768.
  - Otherwise p = a * sum over i>=APPROX_ROWS of d_i*4^i, where d_i are the Booth digits of b.
  - The 18-bit accumulator never overflows: |acc| <= 2^16 + 2^15.
- Boundary conditions:
  - Operands are sampled only on the accepting edge. Changes to a/b during CALC or HOLD are ignored.
  - in_valid while not in IDLE: not accepted; the source must hold it.
  - out_ready asserted while not in HOLD: ignored.
  - Simultaneous out_ready and in_valid in HOLD: the product completes; the new operands are accepted no earlier than the following IDLE cycle.
  - p retains the last product after leaving HOLD, until the next product load or reset.
- Reset and all state transitions are registered; outputs are decoded from registers only, with no combinational in→out paths.

Test Plan:
- Exact small product: a=3, b=5, out_ready=1 -> out_valid high 8 edges after accept, p=0x0000000F, then in_ready=1 the following cycle.
- Extreme operands: a=0x8000, b=0x8000 -> p=0x40000000. Then a=0x7FFF, b=0x8000 -> p=0xC0008000.
- Backpressure: after a=-7, b=9 completes, hold out_ready=0 for 5 cycles with in_valid=1 and new operands applied -> out_valid stays 1, p=0xFFFFFFC1 stable, in_ready=0. After out_ready=1, the new pair is accepted in IDLE and its product is correct.
- Reset mid-operation: assert rst at cnt=4 -> out_valid never asserts, p=0, in_ready=1 the first cycle after rst deasserts. The next op a=2, b=-3 gives p=0xFFFFFFFA.
- Approximation: APPROX_ROWS=2, a=100, b=0x00FF -> p=25600 (0x00006400). With APPROX_ROWS=0 the same operands give 25500.
- Randomized regression: 10k random signed pairs with APPROX_ROWS=0, random out_ready stalls -> every p equals the reference a*b, with no lost or duplicated transactions.

Source files
------------

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth signed 16x16 multiplier: one Booth digit per CALC cycle,
// eight cycles per product, valid/ready handshakes on operand and product sides.
module booth_r4_seq_mult #(
  parameter int APPROX_ROWS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] p,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_e;

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic signed [15:0] a_q, a_d;
  logic signed [17:0] acc_q, acc_d;
  logic [15:0]        lo_q, lo_d;
  logic               prev_q, prev_d;
  logic [31:0]        p_q, p_d;
  logic               out_valid_q, in_ready_q, busy_q;

  logic signed [17:0] pp;
  logic signed [17:0] sum;
  logic signed [33:0] shifted;

  // Booth digit times multiplicand, sign-extended to the accumulator width.
  function automatic logic signed [17:0] booth_pp(input logic [2:0] trip,
                                                  input logic signed [15:0] m);
    logic signed [17:0] mx;
    mx = {{2{m[15]}}, m};
    case (trip)
      3'b001, 3'b010: booth_pp = mx;
      3'b011:         booth_pp = mx <<< 1;
      3'b100:         booth_pp = -(mx <<< 1);
      3'b101, 3'b110: booth_pp = -mx;
      default:        booth_pp = '0;
    endcase
  endfunction

  always_comb begin
    pp = booth_pp({lo_q[1], lo_q[0], prev_q}, a_q);
    if (int'(cnt_q) < APPROX_ROWS) pp = '0;
    sum     = acc_q + pp;
    shifted = $signed({sum, lo_q}) >>> 2;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    prev_d  = prev_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          acc_d   = '0;
          lo_d    = b;
          prev_d  = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d  = shifted[33:16];
        lo_d   = shifted[15:0];
        prev_d = lo_q[1];
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          p_d     = shifted[31:0];
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers; flags are decoded from next state so outputs stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      lo_q        <= lo_d;
      p_q         <= p_d;
      out_valid_q <= (state_d == HOLD);
      in_ready_q  <= (state_d == IDLE);
      busy_q      <= (state_d == CALC);
    end
  end

  always_ff @(posedge clk) begin
    a_q    <= a_d;
    prev_q <= prev_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign p         = p_q;

endmodule
